// File: rtl/comm_pkg.sv
// ============================================================================
// comm_pkg : shared defaults, rx state encoding and packet sizing for the link
// Revision : 1.0
// ============================================================================
`default_nettype none

package comm_pkg;

    localparam int DFLT_CLK_PER_SAMP  = 423;
    localparam int DFLT_SAMP_PER_BIT  = 16;
    localparam int DFLT_PKT_LEN       = 208;
    localparam int DFLT_WAITING_COUNT = 130_000;

    localparam int BYTES_PER_PKT = DFLT_PKT_LEN / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_byte_rx.sv
// ============================================================================
// uart_byte_rx : 8N1 oversampling byte receiver with input synchronizer
// Revision     : 1.0
// ============================================================================
`default_nettype none

module uart_byte_rx
    import comm_pkg::*;
#(
    parameter int CLK_PER_SAMP = DFLT_CLK_PER_SAMP,
    parameter int SAMP_PER_BIT = DFLT_SAMP_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       line_idle,
    output logic       rx_level
);

    localparam int TICK_W = safe_clog2(CLK_PER_SAMP);
    localparam int SAMP_W = safe_clog2(SAMP_PER_BIT);

    localparam logic [TICK_W-1:0] TICK_LAST      = TICK_W'(CLK_PER_SAMP - 1);
    localparam logic [SAMP_W-1:0] SAMP_HALF_LAST = SAMP_W'(SAMP_PER_BIT / 2 - 1);
    localparam logic [SAMP_W-1:0] SAMP_FULL_LAST = SAMP_W'(SAMP_PER_BIT - 1);

    logic              rx_meta;
    logic              rx_sync;
    logic              rx_sync_d;
    logic              fall_edge;
    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [TICK_W-1:0] tick_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic              tick;
    logic              samp_point;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
        end else begin
            rx_meta   <= rx;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
        end
    end

    assign fall_edge  = rx_sync_d & ~rx_sync;
    assign tick       = (state != ST_IDLE) && (tick_cnt == TICK_LAST);
    assign samp_point = tick && (samp_cnt == ((state == ST_START) ? SAMP_HALF_LAST
                                                                   : SAMP_FULL_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (samp_point) begin
                    state_nxt = rx_sync ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (samp_point && (bit_cnt == 3'd7)) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (samp_point) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt   <= '0;
            samp_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            if (state == ST_IDLE) begin
                // Held at zero so timing restarts exactly at the start edge.
                tick_cnt <= '0;
                samp_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
                if (samp_point) begin
                    samp_cnt <= '0;
                end else if (tick) begin
                    samp_cnt <= samp_cnt + SAMP_W'(1);
                end
            end
            if ((state == ST_DATA) && samp_point) begin
                shreg   <= {rx_sync, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if ((state == ST_STOP) && samp_point) begin
                byte_valid <= rx_sync;
                byte_err   <= ~rx_sync;
            end
        end
    end

    assign byte_data = shreg;
    assign line_idle = (state == ST_IDLE);
    assign rx_level  = rx_sync;

endmodule

`default_nettype wire

// File: rtl/board_packet_rx.sv
// ============================================================================
// board_packet_rx : assembles serial bytes into a full game packet with timeout
// Revision        : 1.0
// ============================================================================
`default_nettype none

module board_packet_rx
    import comm_pkg::*;
#(
    parameter int CLK_PER_SAMP  = DFLT_CLK_PER_SAMP,
    parameter int SAMP_PER_BIT  = DFLT_SAMP_PER_BIT,
    parameter int PKT_LEN       = DFLT_PKT_LEN,
    parameter int WAITING_COUNT = DFLT_WAITING_COUNT
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rx,
    output logic               ready,
    output logic [PKT_LEN-1:0] data_out,
    output logic               frame_err
);

    localparam int BYTES  = PKT_LEN / 8;
    localparam int CNT_W  = safe_clog2(BYTES + 1);
    localparam int IDLE_W = safe_clog2(WAITING_COUNT);

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(WAITING_COUNT - 1);

    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_err;
    logic               line_idle;
    logic               rx_level;
    logic [PKT_LEN-1:0] pkt_reg;
    logic [PKT_LEN-1:0] pkt_shifted;
    logic [CNT_W-1:0]   byte_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               pkt_done;
    logic               waiting;
    logic               timeout;

    uart_byte_rx #(
        .CLK_PER_SAMP (CLK_PER_SAMP),
        .SAMP_PER_BIT (SAMP_PER_BIT)
    ) u_byte_rx (
        .clk        (clk_in),
        .rst        (rst_in),
        .rx         (rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .line_idle  (line_idle),
        .rx_level   (rx_level)
    );

    // New bytes enter at the top so the first byte ends up in bits [7:0].
    generate
        if (PKT_LEN > 8) begin : g_multi_byte
            assign pkt_shifted = {byte_data, pkt_reg[PKT_LEN-1:8]};
        end else begin : g_single_byte
            assign pkt_shifted = byte_data;
        end
    endgenerate

    assign waiting = line_idle && (byte_cnt != '0);
    assign timeout = waiting && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pkt_reg   <= '0;
            data_out  <= '0;
            byte_cnt  <= '0;
            idle_cnt  <= '0;
            pkt_done  <= 1'b0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ready     <= 1'b0;
            frame_err <= 1'b0;
            pkt_done  <= 1'b0;
            if (byte_valid) begin
                pkt_reg  <= pkt_shifted;
                byte_cnt <= byte_cnt + CNT_W'(1);
                pkt_done <= (byte_cnt == LAST_BYTE);
                idle_cnt <= '0;
            end else if (byte_err) begin
                frame_err <= 1'b1;
                byte_cnt  <= '0;
                idle_cnt  <= '0;
            end else if (pkt_done) begin
                data_out <= pkt_reg;
                ready    <= 1'b1;
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (timeout) begin
                // Checked ahead of the rx-low reset so a coincident start begins byte 0.
                byte_cnt <= '0;
                idle_cnt <= '0;
            end else if (waiting && rx_level) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_board_packet_rx.sv
// ============================================================================
// tb_board_packet_rx : directed serial stimulus checked against a packet model
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_board_packet_rx;

    localparam int CPS      = 4;
    localparam int SPB      = 16;
    localparam int PL       = 16;
    localparam int WC       = 2000;
    localparam int NBYTES   = PL / 8;
    localparam int BIT_CLKS = CPS * SPB;
    // Cycles from driving the start bit to the stop-bit sample: one clock to
    // reach the first flop, two more to detect the edge, then 8 + 9*16 ticks.
    localparam int STOP_SAMP = 3 + CPS * (SPB / 2 + 9 * SPB);
    localparam int READY_LAT = STOP_SAMP + 2;
    localparam int FERR_LAT  = STOP_SAMP + 1;

    logic          clk    = 1'b0;
    logic          rst_in = 1'b1;
    logic          rx     = 1'b1;
    logic          ready;
    logic          frame_err;
    logic [PL-1:0] data_out;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit checking   = 1'b0;

    int            ready_q[$];
    logic [PL-1:0] val_q[$];
    int            ferr_q[$];
    logic [PL-1:0] exp_data = '0;
    logic [7:0]    m_bytes[NBYTES];
    int            m_cnt     = 0;
    int            last_stop = 0;
    int            ready_seen = 0;
    int            ferr_seen  = 0;

    board_packet_rx #(
        .CLK_PER_SAMP  (CPS),
        .SAMP_PER_BIT  (SPB),
        .PKT_LEN       (PL),
        .WAITING_COUNT (WC)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .rx        (rx),
        .ready     (ready),
        .data_out  (data_out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [PL-1:0] act, input logic [PL-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Packet model: bytes collect until a full packet, a bad stop bit, or an
    // idle gap longer than the timeout since the previous accepted byte.
    task automatic model_byte(input int t0, input logic [7:0] data, input logic stop_bit);
        logic [PL-1:0] pack;
        if (m_cnt > 0 && (t0 - last_stop) > WC) m_cnt = 0;
        if (stop_bit) begin
            m_bytes[m_cnt] = data;
            m_cnt++;
            last_stop = t0 + STOP_SAMP;
            if (m_cnt == NBYTES) begin
                pack = '0;
                for (int k = 0; k < NBYTES; k++) pack[8*k +: 8] = m_bytes[k];
                ready_q.push_back(t0 + READY_LAT);
                val_q.push_back(pack);
                m_cnt = 0;
            end
        end else begin
            ferr_q.push_back(t0 + FERR_LAT);
            m_cnt = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        model_byte(cyc, data, stop_bit);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_clks(BIT_CLKS);
        end
        rx = stop_bit;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        logic er;
        logic ef;
        if (checking && !rst_in) begin
            er = 1'b0;
            ef = 1'b0;
            if (ready_q.size() > 0 && ready_q[0] == cyc) begin
                er       = 1'b1;
                exp_data = val_q[0];
                void'(ready_q.pop_front());
                void'(val_q.pop_front());
            end
            if (ferr_q.size() > 0 && ferr_q[0] == cyc) begin
                ef = 1'b1;
                void'(ferr_q.pop_front());
            end
            if (ready)     ready_seen++;
            if (frame_err) ferr_seen++;
            check("ready", PL'(ready), PL'(er));
            check("frame_err", PL'(frame_err), PL'(ef));
            check("data_out", data_out, exp_data);
        end
    end

    initial begin
        int rs;
        int fs;
        logic [7:0] partial;

        wait_clks(5);
        check("reset ready", PL'(ready), '0);
        check("reset frame_err", PL'(frame_err), '0);
        check("reset data_out", data_out, '0);
        rst_in = 1'b0;
        checking = 1'b1;
        wait_clks(20);

        rs = ready_seen; fs = ferr_seen;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        wait_clks(20);
        check("pkt1 data", data_out, 16'h3CA5);
        check("pkt1 ready count", PL'(ready_seen - rs), PL'(1));
        check("pkt1 no frame_err", PL'(ferr_seen - fs), PL'(0));

        rs = ready_seen;
        rx = 1'b0;
        wait_clks(20);
        rx = 1'b1;
        wait_clks(100);
        check("glitch no ready", PL'(ready_seen - rs), PL'(0));
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_clks(20);
        check("after glitch data", data_out, 16'h2211);
        check("after glitch ready count", PL'(ready_seen - rs), PL'(1));

        fs = ferr_seen;
        send_byte(8'h55, 1'b0);
        wait_clks(100);
        check("ferr data held", data_out, 16'h2211);
        check("ferr pulse count", PL'(ferr_seen - fs), PL'(1));
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_clks(20);
        check("after ferr data", data_out, 16'h0201);

        rs = ready_seen;
        send_byte(8'hFF, 1'b1);
        wait_clks(2500);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        wait_clks(20);
        check("timeout data", data_out, 16'h0201);
        check("timeout ready count", PL'(ready_seen - rs), PL'(1));

        rs = ready_seen;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        wait_clks(20);
        check("pre-reset data", data_out, 16'h3CA5);
        partial = 8'h5A;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            wait_clks(BIT_CLKS);
        end
        rx = partial[4];
        wait_clks(BIT_CLKS / 2);
        rst_in = 1'b1;
        #1;
        check("async reset data_out", data_out, '0);
        check("async reset ready", PL'(ready), '0);
        ready_q.delete();
        val_q.delete();
        ferr_q.delete();
        exp_data = '0;
        m_cnt = 0;
        rx = 1'b1;
        wait_clks(5);
        rst_in = 1'b0;
        wait_clks(50);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        wait_clks(20);
        check("post-reset data", data_out, 16'hBEEF);
        check("reset test ready count", PL'(ready_seen - rs), PL'(2));

        rs = ready_seen;
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'hCD, 1'b1);
        check("b2b first held", data_out, 16'h1234);
        send_byte(8'hAB, 1'b1);
        wait_clks(20);
        check("b2b second data", data_out, 16'hABCD);
        check("b2b ready count", PL'(ready_seen - rs), PL'(2));

        check("pending ready events", PL'(ready_q.size()), PL'(0));
        check("pending frame_err events", PL'(ferr_q.size()), PL'(0));
        checking = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
